mux_scan_sequencer: RTL and testbench
=====================================

Name: mux_scan_sequencer

Overview:
- Scan controller that sits directly upstream and downstream of the 4:1 mux stage.
- Drives the mux select pair {sel0, sel1} through the enabled channels and holds each channel for a programmable settle time.
- Samples the mux output f at the end of each hold and assembles a 4-bit snapshot of all channels.
- Presents the snapshot with a one-cycle valid strobe. It is used to scan four single-bit sources through one shared mux.

Parameters:
- DWELL_W, 4, width of the dwell (settle) count input and the internal hold counter.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a scan; sampled only in IDLE.
- continuous  input  1  when 1 at scan completion, the next scan begins immediately.
- dwell  input  DWELL_W  extra hold cycles per channel; the channel is held dwell+1 cycles.
- ch_en  input  4  channel enable mask; bit k enables channel k.
- f  input  1  mux output being sampled.
- sel0  output  1  mux select MSB; channel index = {sel0, sel1}.
- sel1  output  1  mux select LSB.
- busy  output  1  high while a scan is in progress.
- sample  output  4  last completed snapshot; bit k = f captured for channel k.
- valid  output  1  one-cycle pulse when sample updates.

Behaviour:
- Reset, asynchronous: sel0=0, sel1=0, busy=0, valid=0, sample=4'b0000, FSM=IDLE, hold counter=0, shadow snapshot=0.
- All outputs are registered.
- FSM states: IDLE, HOLD.
- IDLE:
  - sel={0,0}, busy=0.
  - On a clock edge with start=1 and ch_en!=0: latch ch_en and dwell; clear the shadow; load sel with the lowest enabled channel; load the counter with the latched dwell; busy=1; go to HOLD.
  - start=1 with ch_en=0 is ignored; stay in IDLE with no valid pulse.
- HOLD:
  - Each edge with counter!=0 decrements the counter.
  - The edge with counter==0 is the capture edge: shadow[ch]=f, where ch is the current {sel0, sel1}.
  - If a higher enabled channel exists in the latched mask, sel moves to the next enabled channel (ascending, disabled channels skipped) and the counter reloads the latched dwell.
  - Otherwise this is the last capture. At the same edge: sample={new shadow with bit ch written}, with disabled-channel bits forced to 0; valid=1 for exactly one cycle.
    - If continuous=1: re-latch ch_en and dwell, clear the shadow, and load sel with the lowest enabled channel of the new mask. If the new ch_en=0, go to IDLE instead.
    - If continuous=0: go to IDLE, busy=0, sel={0,0}.
- Timing: the channel is held for dwell+1 cycles before capture. With all four channels enabled, the scan takes 4*(dwell+1) cycles from the start edge to the valid edge.
- Between completions, valid=0 and sample holds its value.
- start while busy is ignored.
- ch_en and dwell changes mid-scan have no effect until re-latch.
- f is treated as synchronous to clk; no synchroniser is included.
- Counter arithmetic is unsigned DWELL_W-bit.
- dwell = 2^DWELL_W-1 is legal; the hold is then 2^DWELL_W cycles. There is no wrap-around during a hold.
- rst_n asserted mid-scan: immediate return to reset values. The partial snapshot is discarded and there is no valid pulse.

Test Plan:
- Full scan: ch_en=1111, dwell=2, mux inputs i0..i3=1,0,1,1, start pulse at edge E0.
  - Expected sel sequence: 00 for edges E0..E3, then 01, 10, 11, each held 3 cycles.
  - valid high for one cycle after E0+12; sample=4'b1101; busy falls at E0+12.
- Masked scan: ch_en=1010, dwell=0, i1=1, i3=0.
  - Expected: sel visits only 01 then 11, one cycle each.
  - valid after E0+2; sample=4'b0010.
- Continuous mode: continuous=1, ch_en=0001, dwell=1, i0 toggled to 0 after the first valid.
  - Expected: valid every 2 cycles; sample goes 0001 then 0000; busy stays 1.
  - Drop continuous: the FSM returns to IDLE after the next valid.
- Ignored requests:
  - start with ch_en=0000: busy stays 0, no valid, sample unchanged.
  - start asserted during a scan: no restart; total scan length is unchanged.
- Reset mid-scan: assert rst_n=0 during the channel-2 hold of a 1111 scan.
  - Expected: sel=00, busy=0, sample=0000 immediately, and no valid pulse.
  - After release, a new start scans normally.
- Maximum dwell: dwell=4'hF, ch_en=0100.
  - Expected: sel=10 held 16 cycles; valid after E0+16 with sample bit 2 equal to i2.

Source files
------------

// File: rtl/mux_scan_if.sv
// Signal bundle between the scan sequencer and the shared 4:1 mux and its consumer.
// valid is a one-cycle strobe with no ready: the consumer must take sample on the cycle valid is high.
interface mux_scan_if #(
    parameter int DWELL_W = 4
);
    logic               start;
    logic               continuous;
    logic [DWELL_W-1:0] dwell;
    logic [3:0]         ch_en;
    logic               f;
    logic               sel0;
    logic               sel1;
    logic               busy;
    logic [3:0]         sample;
    logic               valid;
    logic               scan_state;   // debug view of the FSM: 0 = IDLE, 1 = HOLD

    modport master (
        output start, continuous, dwell, ch_en, f,
        input  sel0, sel1, busy, sample, valid, scan_state
    );

    modport slave (
        input  start, continuous, dwell, ch_en, f,
        output sel0, sel1, busy, sample, valid, scan_state
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps a shared 4:1 mux through the enabled channels and holds each one for dwell+1 cycles.
// It captures f at the end of each hold and publishes a 4-bit snapshot with a one-cycle valid.
module mux_scan_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    mux_scan_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t             state, state_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [DWELL_W-1:0] dwell_l, dwell_n;
    logic [3:0]         mask, mask_n;
    logic [3:0]         shadow, shadow_n;
    logic [3:0]         sample_r, sample_n;
    logic [1:0]         sel, sel_n;
    logic               busy_r, busy_n;
    logic               valid_r, valid_n;
    logic [3:0]         captured;
    logic [2:0]         next_ch;

    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (m[k]) idx = 2'(k);
        end
        return idx;
    endfunction

    // Returns {found, index} of the lowest enabled channel strictly above cur.
    function automatic logic [2:0] above_ch(input logic [3:0] m, input logic [1:0] cur);
        logic [2:0] res;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            if (m[k] && (k > int'(cur))) res = {1'b1, 2'(k)};
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            dwell_l  <= '0;
            mask     <= 4'b0000;
            shadow   <= 4'b0000;
            sample_r <= 4'b0000;
            sel      <= 2'b00;
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            dwell_l  <= dwell_n;
            mask     <= mask_n;
            shadow   <= shadow_n;
            sample_r <= sample_n;
            sel      <= sel_n;
            busy_r   <= busy_n;
            valid_r  <= valid_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        dwell_n  = dwell_l;
        mask_n   = mask;
        shadow_n = shadow;
        sample_n = sample_r;
        sel_n    = sel;
        busy_n   = busy_r;
        valid_n  = 1'b0;
        captured = shadow;
        captured[sel] = bus.f;
        next_ch  = above_ch(mask, sel);

        case (state)
            IDLE: begin
                sel_n  = 2'b00;
                busy_n = 1'b0;
                if (bus.start && (bus.ch_en != 4'b0000)) begin
                    mask_n   = bus.ch_en;
                    dwell_n  = bus.dwell;
                    shadow_n = 4'b0000;
                    sel_n    = lowest_ch(bus.ch_en);
                    cnt_n    = bus.dwell;
                    busy_n   = 1'b1;
                    state_n  = HOLD;
                end
            end
            HOLD: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (next_ch[2]) begin
                    shadow_n = captured;
                    sel_n    = next_ch[1:0];
                    cnt_n    = dwell_l;
                end else begin
                    // Last capture of the scan: publish, then either chain or stop.
                    sample_n = captured & mask;
                    valid_n  = 1'b1;
                    if (bus.continuous && (bus.ch_en != 4'b0000)) begin
                        mask_n   = bus.ch_en;
                        dwell_n  = bus.dwell;
                        shadow_n = 4'b0000;
                        sel_n    = lowest_ch(bus.ch_en);
                        cnt_n    = bus.dwell;
                    end else begin
                        shadow_n = captured;
                        state_n  = IDLE;
                        busy_n   = 1'b0;
                        sel_n    = 2'b00;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.sel0       = sel[1];
    assign bus.sel1       = sel[0];
    assign bus.busy       = busy_r;
    assign bus.sample     = sample_r;
    assign bus.valid      = valid_r;
    assign bus.scan_state = state;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: a mux model feeds f, and each scan's expected select
// sequence and snapshot are derived from the enable mask, dwell and mux inputs.
module tb_mux_scan_sequencer;
  localparam int DWELL_W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] mux_in = 4'b0000;
  logic [3:0] exp_sample = 4'b0000;
  logic [1:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  mux_scan_if #(.DWELL_W(DWELL_W)) bus ();

  mux_scan_sequencer #(.DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.f = mux_in[{bus.sel0, bus.sel1}];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  8'(bus.busy), 8'd0);
    check({tag, "_valid"}, 8'(bus.valid), 8'd0);
    check({tag, "_sel"},   8'({bus.sel0, bus.sel1}), 8'd0);
    check({tag, "_sample"}, 8'(bus.sample), 8'(exp_sample));
    check({tag, "_state"}, 8'(bus.scan_state), 8'd0);
  endtask

  // One non-continuous scan; noisy toggles start/ch_en/dwell mid-scan, which must not matter.
  task automatic run_scan(input logic [3:0] m, input logic [3:0] d,
                          input logic [3:0] ins, input bit noisy);
    int         total;
    logic [1:0] ch;
    exp_q.delete();
    for (int k = 0; k < 4; k++)
      if (m[k])
        for (int r = 0; r <= int'(d); r++) exp_q.push_back(2'(k));
    total = exp_q.size();
    bus.ch_en      = m;
    bus.dwell      = d;
    bus.continuous = 1'b0;
    bus.start      = 1'b1;
    mux_in         = ins;
    next_cycle();
    bus.start = 1'b0;
    for (int i = 0; i < total; i++) begin
      ch = exp_q.pop_front();
      check("scan_sel",   8'({bus.sel0, bus.sel1}), 8'(ch));
      check("scan_busy",  8'(bus.busy), 8'd1);
      check("scan_valid", 8'(bus.valid), 8'd0);
      if (noisy) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.ch_en = 4'($urandom);
        bus.dwell = 4'($urandom);
      end
      next_cycle();
    end
    bus.start  = 1'b0;
    exp_sample = ins & m;
    check("done_valid",  8'(bus.valid), 8'd1);
    check("done_sample", 8'(bus.sample), 8'(exp_sample));
    check("done_busy",   8'(bus.busy), 8'd0);
    check("done_sel",    8'({bus.sel0, bus.sel1}), 8'd0);
    next_cycle();
    check_idle("after");
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.continuous = 1'b0;
    bus.dwell      = '0;
    bus.ch_en      = 4'b0000;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    next_cycle();

    // Directed scans from the plan.
    run_scan(4'b1111, 4'd2, 4'b1101, 1'b0);
    run_scan(4'b1010, 4'd0, 4'b0010, 1'b0);
    run_scan(4'b0100, 4'hF, 4'($urandom), 1'b0);

    // Request with an empty mask is dropped.
    bus.ch_en = 4'b0000;
    bus.start = 1'b1;
    repeat (3) begin
      next_cycle();
      check_idle("empty_mask");
    end
    bus.start = 1'b0;

    // Continuous single-channel scan: snapshot every dwell+1 = 2 cycles.
    bus.ch_en      = 4'b0001;
    bus.dwell      = 4'd1;
    bus.continuous = 1'b1;
    mux_in         = 4'b0001;
    bus.start      = 1'b1;
    next_cycle();
    bus.start = 1'b0;
    check("cont_valid0", 8'(bus.valid), 8'd0);
    check("cont_busy0",  8'(bus.busy), 8'd1);
    next_cycle();
    check("cont_valid1", 8'(bus.valid), 8'd0);
    next_cycle();
    check("cont_valid2", 8'(bus.valid), 8'd1);
    check("cont_sample2", 8'(bus.sample), 8'b0001);
    check("cont_busy2",  8'(bus.busy), 8'd1);
    mux_in = 4'b0000;
    next_cycle();
    check("cont_valid3", 8'(bus.valid), 8'd0);
    check("cont_sample3", 8'(bus.sample), 8'b0001);
    next_cycle();
    check("cont_valid4", 8'(bus.valid), 8'd1);
    check("cont_sample4", 8'(bus.sample), 8'b0000);
    check("cont_busy4",  8'(bus.busy), 8'd1);
    bus.continuous = 1'b0;
    next_cycle();
    check("cont_valid5", 8'(bus.valid), 8'd0);
    check("cont_busy5",  8'(bus.busy), 8'd1);
    next_cycle();
    check("cont_valid6", 8'(bus.valid), 8'd1);
    check("cont_busy6",  8'(bus.busy), 8'd0);
    exp_sample = 4'b0000;
    next_cycle();
    check_idle("cont_end");

    // Reset during the channel-2 hold of a full scan.
    bus.ch_en = 4'b1111;
    bus.dwell = 4'd2;
    mux_in    = 4'b1111;
    bus.start = 1'b1;
    next_cycle();
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("pre_rst_sel", 8'({bus.sel0, bus.sel1}), 8'd2);
    rst_n = 1'b0;
    #1;
    exp_sample = 4'b0000;
    check_idle("mid_rst");
    repeat (2) begin
      @(negedge clk);
      check_idle("in_rst");
    end
    rst_n = 1'b1;
    repeat (12) begin
      next_cycle();
      check_idle("post_rst");
    end
    run_scan(4'b1111, 4'd1, 4'b0110, 1'b0);

    // Randomized scans, half of them with mid-scan noise on start/ch_en/dwell.
    for (int n = 0; n < 24; n++) begin
      logic [3:0] m;
      logic [3:0] d;
      m = 4'($urandom_range(1, 15));
      d = (n % 8 == 7) ? 4'hF : 4'($urandom_range(0, 3));
      run_scan(m, d, 4'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
